// File: rtl/btn_debounce_pkg.sv
// rtl/btn_debounce_pkg.sv - shared types and constants for the button debouncer
package btn_debounce_pkg;

  localparam int BTN_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_t;

endpackage

// File: rtl/btn_debounce_if.sv
// rtl/btn_debounce_if.sv - button pin and conditioned outputs bundle
interface btn_debounce_if;

  logic       btn_raw;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic [7:0] press_count;

  // master = debouncer side, slave = pin driver / downstream consumer side
  modport master (
    input  btn_raw,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output press_count
  );

  modport slave (
    output btn_raw,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  press_count
  );

endinterface

// File: rtl/btn_debounce_sync_2ff.sv
// rtl/btn_debounce_sync_2ff.sv - two-flop synchroniser with configurable reset level
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button debouncer with press/release strobes.
// Optional auto-repeat of press_pulse while held: BTN_DEBOUNCE_AUTOREPEAT_EN.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 25000000
) (
  input  logic          clk,
  input  logic          reset,
  btn_debounce_if.master bus
);

  localparam bit IDLE_LVL = (ACTIVE_LOW != 0);
  localparam bit SINGLE   = (DEBOUNCE_CYCLES == 1);
  // The sample that leaves IDLE/HELD is the first stable one, so the CHK
  // state only needs DEBOUNCE_CYCLES-1 further samples.
  localparam logic [BTN_CNT_W-1:0] CNT_LAST =
    BTN_CNT_W'((DEBOUNCE_CYCLES >= 2) ? (DEBOUNCE_CYCLES - 2) : 0);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("btn_debounce: cycle parameters must be at least 1");
  end

  logic                 raw_sync;
  logic                 s;
  btn_state_t           state, state_d;
  logic [BTN_CNT_W-1:0] cnt;
  logic                 press_fsm;
  logic                 release_fsm;
  logic                 rep_fire;

  logic                 level_q;
  logic                 press_q;
  logic                 release_q;
  logic [7:0]           count_q;

  sync_2ff #(.RESET_VAL(IDLE_LVL)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.btn_raw),
    .q     (raw_sync)
  );

  assign s = raw_sync ^ IDLE_LVL;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (s) state_d = SINGLE ? HELD : PRESS_CHK;
      end
      PRESS_CHK: begin
        if (!s)                  state_d = IDLE;
        else if (cnt == CNT_LAST) state_d = HELD;
      end
      HELD: begin
        if (!s) state_d = SINGLE ? IDLE : RELEASE_CHK;
      end
      RELEASE_CHK: begin
        if (s)                   state_d = HELD;
        else if (cnt == CNT_LAST) state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    press_fsm   = 1'b0;
    release_fsm = 1'b0;
    if ((state == IDLE || state == PRESS_CHK) && state_d == HELD)
      press_fsm = 1'b1;
    if ((state == HELD || state == RELEASE_CHK) && state_d == IDLE)
      release_fsm = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if ((state == PRESS_CHK || state == RELEASE_CHK) && state_d == state) begin
      cnt <= cnt + BTN_CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  logic [BTN_CNT_W-1:0] rep_timer;
  logic [BTN_CNT_W-1:0] rep_limit;
  logic                 rep_armed;

  assign rep_limit = rep_armed ? BTN_CNT_W'(REPEAT_PERIOD - 1)
                               : BTN_CNT_W'(REPEAT_DELAY - 1);
  // Requiring state_d == HELD drops a repeat that lands on the release edge.
  assign rep_fire  = (state == HELD) && (state_d == HELD) && (rep_timer == rep_limit);

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_timer <= '0;
      rep_armed <= 1'b0;
    end else if (state_d == IDLE || state_d == PRESS_CHK) begin
      rep_timer <= '0;
      rep_armed <= 1'b0;
    end else if (rep_fire) begin
      rep_timer <= '0;
      rep_armed <= 1'b1;
    end else if (state == HELD && state_d == HELD) begin
      rep_timer <= rep_timer + BTN_CNT_W'(1);
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      level_q   <= (state_d == HELD) || (state_d == RELEASE_CHK);
      press_q   <= press_fsm | rep_fire;
      release_q <= release_fsm;
      if (press_fsm) count_q <= count_q + 8'd1;
    end
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.press_count   = count_q;

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - directed self-checking bench for btn_debounce
module tb_btn_debounce;

  logic clk;
  logic reset;

  btn_debounce_if bus ();

  btn_debounce #(
    .DEBOUNCE_CYCLES (8),
    .ACTIVE_LOW      (1),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam int REP = 1;
`else
  localparam int REP = 0;
`endif

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  int press_n   = 0;
  int release_n = 0;
  int level_n   = 0;
  int both_n    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    press_n   <= press_n + int'(bus.press_pulse);
    release_n <= release_n + int'(bus.release_pulse);
    level_n   <= level_n + int'(bus.btn_level);
    both_n    <= both_n + int'(bus.press_pulse & bus.release_pulse);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic go_to(input int n);
    repeat (n - cyc) @(posedge clk);
    cyc = n;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  int k;
  int r;
  int p;
  int snap_p;
  int snap_r;
  int snap_l;

  initial begin
    reset       = 1'b1;
    bus.btn_raw = 1'b1;

    go_to(3);
    chk("rst_level",   32'(bus.btn_level),     0);
    chk("rst_press",   32'(bus.press_pulse),   0);
    chk("rst_release", 32'(bus.release_pulse), 0);
    chk("rst_count",   32'(bus.press_count),   0);
    reset = 1'b0;

    // clean press sampled at edge 10 -> strobe after edge 19
    go_to(9);
    bus.btn_raw = 1'b0;
    go_to(18);
    chk("press_early", 32'(bus.press_pulse), 0);
    chk("level_early", 32'(bus.btn_level),   0);
    go_to(19);
    chk("press_pulse", 32'(bus.press_pulse), 1);
    chk("press_level", 32'(bus.btn_level),   1);
    chk("press_count", 32'(bus.press_count), 1);
    go_to(20);
    chk("press_width", 32'(bus.press_pulse), 0);

    // release with a one-cycle low glitch on the 4th sample
    go_to(30);
    chk("held_pulses", 32'(press_n), 1);
    bus.btn_raw = 1'b1;
    go_to(33);
    bus.btn_raw = 1'b0;
    go_to(34);
    bus.btn_raw = 1'b1;
    go_to(43);
    chk("rel_early",       32'(bus.release_pulse), 0);
    chk("rel_level_early", 32'(bus.btn_level),     1);
    go_to(44);
    chk("rel_pulse", 32'(bus.release_pulse), 1);
    chk("rel_level", 32'(bus.btn_level),     0);
    go_to(45);
    chk("rel_width", 32'(bus.release_pulse), 0);
    go_to(55);
    chk("rel_once",      32'(release_n),       1);
    chk("rel_count_hold", 32'(bus.press_count), 1);

    // bounce: 3-cycle runs never reach the 8-sample window
    snap_p = press_n;
    snap_r = release_n;
    snap_l = level_n;
    for (int i = 0; i < 40; i++) begin
      bus.btn_raw = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      go_to(cyc + 1);
    end
    bus.btn_raw = 1'b1;
    go_to(cyc + 20);
    chk("bounce_press",   32'(press_n - snap_p),   0);
    chk("bounce_release", 32'(release_n - snap_r), 0);
    chk("bounce_level",   32'(level_n - snap_l),   0);

    // reset in the middle of PRESS_CHK with the button still held
    bus.btn_raw = 1'b0;
    k = cyc + 1;
    snap_p = press_n;
    go_to(k + 6);
    chk("midrst_nopulse", 32'(press_n - snap_p), 0);
    reset = 1'b1;
    go_to(k + 8);
    chk("midrst_level", 32'(bus.btn_level),   0);
    chk("midrst_count", 32'(bus.press_count), 0);
    reset = 1'b0;
    r = k + 9;
    go_to(r + 8);
    chk("midrst_early", 32'(bus.press_pulse), 0);
    go_to(r + 9);
    chk("midrst_pulse", 32'(bus.press_pulse), 1);
    chk("midrst_cnt1",  32'(bus.press_count), 1);

    // counter wrap over 256 presses from a fresh reset
    bus.btn_raw = 1'b1;
    go_to(cyc + 14);
    reset = 1'b1;
    go_to(cyc + 2);
    reset = 1'b0;
    snap_p = press_n;
    snap_r = release_n;
    for (int i = 0; i < 256; i++) begin
      bus.btn_raw = 1'b0;
      go_to(cyc + 14);
      bus.btn_raw = 1'b1;
      go_to(cyc + 14);
      if (i == 254) chk("wrap_255", 32'(bus.press_count), 255);
    end
    chk("wrap_count",    32'(bus.press_count),  0);
    chk("wrap_pulses",   32'(press_n - snap_p),  256);
    chk("wrap_releases", 32'(release_n - snap_r), 256);

    // long hold: repeats only when auto-repeat is compiled in
    bus.btn_raw = 1'b0;
    p = cyc + 10;
    go_to(p);
    chk("hold_first", 32'(bus.press_pulse), 1);
    snap_p = press_n;
    go_to(p + 20);
    chk("hold_rep20", 32'(bus.press_pulse), 32'(REP));
    go_to(p + 25);
    chk("hold_gap25", 32'(bus.press_pulse), 0);
    go_to(p + 50);
    chk("hold_rep50", 32'(bus.press_pulse), 32'(REP));
    go_to(p + 59);
    chk("hold_pulses", 32'(press_n - snap_p), 32'(1 + 4 * REP));
    chk("hold_count",  32'(bus.press_count),  1);
    bus.btn_raw = 1'b1;
    go_to(cyc + 20);
    chk("hold_level_off", 32'(bus.btn_level), 0);

    chk("never_both", 32'(both_n), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
